// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational shifter between the ALU issue path and the LSU alignment path.
// Optional grant counters are enabled with `define SHIFT_ARB_STATS_EN.
module shift_arbiter #(
  parameter int unsigned RESET_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in,
  input  logic [4:0]  req0_shamt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in,
  input  logic [4:0]  req1_shamt,
  input  logic [1:0]  req1_op,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_shamt,
  output logic [1:0]  sh_op,
  input  logic [31:0] sh_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
`ifdef SHIFT_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  output logic        rsp_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_t;

  // Pointer holds the last granted ID; reset it to the opposite of RESET_PRIO so that one wins first.
  localparam logic LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  state_t      r_state;
  logic        r_last;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_can_accept;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic        w_illegal;
  logic [31:0] w_next_data;

  assign w_can_accept = (r_state == S_IDLE) | (r_rsp_valid & rsp_ready);
  assign w_any_gnt    = w_gnt0 | w_gnt1;

  // Round-robin grant selection.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_can_accept) begin
      if (req0_valid && req1_valid) begin
        if (r_last) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Shifter input mux; requester 0 fields pass through when nobody is granted.
  always_comb begin
    sh_in    = req0_in;
    sh_shamt = req0_shamt;
    sh_op    = req0_op;
    if (w_gnt1) begin
      sh_in    = req1_in;
      sh_shamt = req1_shamt;
      sh_op    = req1_op;
    end else begin
      sh_in    = req0_in;
      sh_shamt = req0_shamt;
      sh_op    = req0_op;
    end
  end

  assign w_illegal   = (sh_op == 2'b11);
  assign w_next_data = w_illegal ? 32'h0000_0000 : sh_out;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Response slot FSM with registered response fields and grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= LAST_RST;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_gnt) begin
            r_state     <= S_FULL;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt1;
            r_last      <= w_gnt1;
            r_rsp_data  <= w_next_data;
            r_rsp_err   <= w_illegal;
          end
        end
        S_FULL: begin
          if (w_any_gnt) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt1;
            r_last      <= w_gnt1;
            r_rsp_data  <= w_next_data;
            r_rsp_err   <= w_illegal;
          end else if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

`ifdef SHIFT_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Saturating grant counters, illegal-op grants included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_gnt0 && (r_cnt0 != CNT_MAX)) begin
        r_cnt0 <= r_cnt0 + CNT_ONE;
      end
      if (w_gnt1 && (r_cnt1 != CNT_MAX)) begin
        r_cnt1 <= r_cnt1 + CNT_ONE;
      end
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a vector table for steady-state behaviour plus
// hand sequences for async reset, post-reset priority and (optionally) counter saturation.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in, req1_in;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] sh_in, sh_out;
  logic [4:0]  sh_shamt;
  logic [1:0]  sh_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.RESET_PRIO(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_op(sh_op), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data),
`ifdef SHIFT_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .rsp_err(rsp_err)
  );

  // External shifter; op 11 returns the operand so a leak into rsp_data is visible.
  always_comb begin
    case (sh_op)
      2'b00:   sh_out = sh_in << sh_shamt;
      2'b01:   sh_out = $unsigned($signed(sh_in) >>> sh_shamt);
      2'b10:   sh_out = sh_in >> sh_shamt;
      default: sh_out = sh_in;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [31:0] in0;
    logic [4:0]  s0;
    logic [1:0]  op0;
    logic        v1;
    logic [31:0] in1;
    logic [4:0]  s1;
    logic [1:0]  op1;
    logic        rr;
    logic        e_r0;
    logic        e_r1;
    logic        e_v;
    logic        e_id;
    logic [31:0] e_d;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v0, input logic [31:0] in0, input logic [4:0] s0, input logic [1:0] op0,
    input logic v1, input logic [31:0] in1, input logic [4:0] s1, input logic [1:0] op1,
    input logic rr, input logic e_r0, input logic e_r1, input logic e_v, input logic e_id,
    input logic [31:0] e_d, input logic e_err);
    vec_t t;
    t.v0 = v0; t.in0 = in0; t.s0 = s0; t.op0 = op0;
    t.v1 = v1; t.in1 = in1; t.s1 = s1; t.op1 = op1;
    t.rr = rr; t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_v = e_v; t.e_id = e_id;
    t.e_d = e_d; t.e_err = e_err;
    return t;
  endfunction

  task automatic drive(input logic v0, input logic [31:0] in0, input logic [4:0] s0,
                       input logic [1:0] op0, input logic v1, input logic [31:0] in1,
                       input logic [4:0] s1, input logic [1:0] op1, input logic rr);
    req0_valid = v0; req0_in = in0; req0_shamt = s0; req0_op = op0;
    req1_valid = v1; req1_in = in1; req1_shamt = s1; req1_op = op1;
    rsp_ready  = rr;
  endtask

  initial begin
    // Columns: req0 {v,in,shamt,op}, req1 {v,in,shamt,op}, rsp_ready | ready0, ready1, then next-cycle valid, id, data, err
    vecs.push_back(mk(1'b1, 32'h0000_00F0, 5'd4,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0F00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 32'h8000_0000, 5'd31, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 32'h8000_0000, 5'd31, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0001, 5'd1,  2'b00, 1'b1, 32'hF000_0000, 5'd4,  2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0001, 5'd1,  2'b00, 1'b1, 32'hF000_0000, 5'd4,  2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0F00_0000, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0001, 5'd1,  2'b00, 1'b1, 32'hF000_0000, 5'd4,  2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0001, 5'd1,  2'b00, 1'b1, 32'hF000_0000, 5'd4,  2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0F00_0000, 1'b0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1, 32'h0000_0001, 5'd1, 2'b00, 1'b1, 32'hF000_0000, 5'd4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0F00_0000, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0001, 5'd1,  2'b00, 1'b1, 32'hF000_0000, 5'd4,  2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b0));
    vecs.push_back(mk(1'b1, 32'h1234_5678, 5'd0,  2'b11, 1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_00F0, 5'd4,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0F00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0F00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0F00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 32'h0000_0003, 5'd1,  2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0006, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_00F0, 5'd4,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0006, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         5'd0,  2'b00, 1'b0, 32'h0,         5'd0,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0006, 1'b0));

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_id",    {31'h0, rsp_id},    32'h0);
    chk("reset_rsp_data",  rsp_data,           32'h0);
    chk("reset_rsp_err",   {31'h0, rsp_err},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].in0, vecs[i].s0, vecs[i].op0,
            vecs[i].v1, vecs[i].in1, vecs[i].s1, vecs[i].op1, vecs[i].rr);
      #1;
      chk($sformatf("v%0d_req0_ready", i), {31'h0, req0_ready}, {31'h0, vecs[i].e_r0});
      chk($sformatf("v%0d_req1_ready", i), {31'h0, req1_ready}, {31'h0, vecs[i].e_r1});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), {31'h0, rsp_valid}, {31'h0, vecs[i].e_v});
      chk($sformatf("v%0d_rsp_id", i),    {31'h0, rsp_id},    {31'h0, vecs[i].e_id});
      chk($sformatf("v%0d_rsp_data", i),  rsp_data,           vecs[i].e_d);
      chk($sformatf("v%0d_rsp_err", i),   {31'h0, rsp_err},   {31'h0, vecs[i].e_err});
    end

    // Fill the slot, then pull reset low between clock edges.
    @(negedge clk);
    drive(1'b1, 32'h0000_00F0, 5'd4, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
    chk("prereset_full", {31'h0, rsp_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("async_rst_data",  rsp_data,           32'h0);
`ifdef SHIFT_ARB_STATS_EN
    chk("async_rst_cnt0", {16'h0, grant_cnt0}, 32'h0);
    chk("async_rst_cnt1", {16'h0, grant_cnt1}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // First contested cycle after reset goes to requester 0.
    @(negedge clk);
    drive(1'b1, 32'h0000_0001, 5'd3, 2'b00, 1'b1, 32'h0000_0100, 5'd4, 2'b10, 1'b1);
    #1;
    chk("postrst_ready0", {31'h0, req0_ready}, 32'h1);
    chk("postrst_ready1", {31'h0, req1_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_id",   {31'h0, rsp_id}, 32'h0);
    chk("postrst_data", rsp_data,        32'h0000_0008);

`ifdef SHIFT_ARB_STATS_EN
    @(negedge clk);
    drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 32'h0000_0100, 5'd4, 2'b10, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h0000_0001, 5'd0, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt0", {16'h0, grant_cnt0}, 32'h0000_FFFF);
    chk("sat_cnt1", {16'h0, grant_cnt1}, 32'h0000_0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational shifter instance (32-bit data, 5-bit shamt, 2-bit op select) between two requesters: requester 0 is the ALU issue path, requester 1 is the load/store alignment path. Round-robin arbitration with valid/ready handshakes on both request ports. The shifter result is captured into a single registered response slot tagged with the requester ID. The block sits beside the ALU and drives the shifter's inputs directly.

Parameters:
RESET_PRIO, 0, requester given priority on the first contested cycle after reset (0 or 1)
CNT_W, 16, width of grant counters (Optional Feature only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_in  input  32  requester 0 operand
req0_shamt  input  5  requester 0 shift amount
req0_op  input  2  requester 0 op: 00 SLL, 01 SRA, 10 SRL, 11 illegal
req1_valid / req1_ready / req1_in / req1_shamt / req1_op  same as requester 0, for requester 1
sh_in  output  32  to shifter operand
sh_shamt  output  5  to shifter shift amount
sh_op  output  2  to shifter op select
sh_out  input  32  from shifter result
rsp_valid  output  1  response slot full
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that owns the response
rsp_data  output  32  shift result
rsp_err  output  1  request had op 11
grant_cnt0, grant_cnt1  output  CNT_W each  grant counters (Optional Feature only)

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last-grant pointer set so RESET_PRIO wins first, state IDLE. Reset mid-transaction drops the held response.
- States: IDLE (slot empty), FULL (slot holds response).
- can_accept = (state==IDLE) | (rsp_valid & rsp_ready).
- Arbitration (combinational, when can_accept): only one valid wins; if both are valid, the requester not granted last wins; if neither is valid, no grant and the pointer is unchanged.
- reqN_ready = can_accept & grant to N. At most one ready is high per cycle, and neither is high while the slot is full and not draining.
- sh_in/sh_shamt/sh_op follow the granted requester's fields. With no grant they hold requester 0's fields, a don't-care.
- On the grant edge: rsp_data<=sh_out, rsp_id<=granted ID, rsp_err<=0, state->FULL, pointer updates to the granted ID.
- op 11: the grant still occurs, rsp_data<=0, rsp_err<=1, shifter output ignored.
- Latency: request accepted in cycle T, rsp_valid high in T+1.
- Back-to-back: a response drained and a new grant in the same cycle keeps rsp_valid high with new contents next cycle. Sustained throughput is 1 per cycle when rsp_ready is held high.
- Drain without a new grant: state->IDLE, rsp_valid<=0. rsp_data/id/err hold their last values.
- While rsp_valid=1 & rsp_ready=0: all rsp_* outputs stable.
- Requesters must hold request fields stable while valid & !ready. Dropping valid before ready is permitted; no grant results.
- shamt uses the full 5 bits. SRA replicates bit 31, SRL zero-fills. Shift semantics are owned by the shifter.

Optional Feature:
SHIFT_ARB_STATS_EN
- Defined: grant_cnt0/grant_cnt1 ports exist. Each increments by 1 on every grant to its requester, including op 11 grants. Each saturates at all-ones with no wrap and resets to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset, then req0 {in=0x0000_00F0, shamt=4, op=00} with rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0000_0F00, rsp_err=0.
2. req1 {0x8000_0000, shamt=31, op=01}, then {0x8000_0000, shamt=31, op=10} -> rsp_data=0xFFFF_FFFF, then rsp_data=0x0000_0001; both with rsp_id=1.
3. Both valid continuously, rsp_ready=1, RESET_PRIO=0 -> grants alternate 0,1,0,1; one response per cycle; rsp_id matches the grant order.
4. rsp_ready=0 for 3 cycles with the slot full and both valid -> both readies stay 0 and rsp_* stay stable. Raise rsp_ready -> the same-cycle grant goes to the requester not granted last; rsp_valid never drops.
5. req0 op=11, in=0x1234_5678 -> rsp_err=1, rsp_data=0. The next legal request yields rsp_err=0.
6. Assert rst_n low asynchronously while the slot is full -> rsp_valid=0 immediately. With SHIFT_ARB_STATS_EN: 70000 grants to req0 -> grant_cnt0=0xFFFF, grant_cnt1 unchanged.
